decode_stage_p: RTL
===================

# decode_stage_p

Parametrised instruction-decode stage for the pipelined core: decodes the 33-bit instruction, reads a 2-read/1-write register file, sign-extends the immediate, and registers everything into the ID/EX pipeline register. Unlike the previous fixed-width stage, it has:
- configurable data, PC and register-address widths;
- stall/flush control with a valid bit;
- load-use hazard detection;
- optional write-through bypass.

It sits between the fetch stage and the execute cycle.

## Interface
- DATA_W, 18, register/immediate data width (must be ≥ 18)
- PC_W, 9, program-counter width
- RA_W, 5, register-address width; register count = 2**RA_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- instr_d  in  33  instruction: [32]=Inm, [31:30]=tipo, [29:28]=op, [27:23]=rs1, [22:18]=rs2, [17:0]=imm, [4:0]=rd (reg form)
- valid_d  in  1  instr_d is a real instruction
- pc_d, pc_plus4_d  in  PC_W  fetch-stage PCs
- stall  in  1  hold ID/EX register contents
- flush  in  1  load a bubble into ID/EX
- reg_write_w  in  1  writeback enable
- rd_w  in  RA_W  writeback address
- result_w  in  DATA_W  writeback data
- valid_e, reg_write_e, alu_src_e, mem_write_e, result_src_e, branch_e  out  1  registered controls
- alu_control_e  out  3  registered ALU opcode
- rgb_e  out  2  registered colour field
- rd1_e, rd2_e, imm_e  out  DATA_W  registered operands / immediate
- rs1_e, rs2_e, rd_e  out  RA_W  registered register addresses
- pc_e, pc_plus4_e  out  PC_W  registered PCs
- hazard  out  1  combinational load-use stall request to fetch

## Operation

**Decode (combinational, by tipo):**
- 00 ALU: reg_write=1, alu_src=Inm, alu_control={0,op}.
- 01 memory:
  - op=00 load: reg_write=1, alu_src=1, result_src=1, alu_control=000.
  - op=01 store: mem_write=1, alu_src=1.
  - op=1x: all controls 0.
- 10 branch: branch=1, alu_control=001.
- 11 colour: rgb=op; all other controls 0.
- Any control not listed above is 0.

**Fields:**
- Destination: tipo=01 → rs1 field; else Inm=1 → rs2 field; else [4:0].
- imm = sign-extend instr_d[17:0] to DATA_W.

**Register file:**
- Reset clears all entries.
- Register 0 reads 0 and ignores writes.
- Write on the clock edge when reg_write_w=1 and rd_w≠0.
- Writes occur regardless of stall/flush.

**Hazard:**
- hazard=1 when valid_e & result_src_e & rd_e≠0 & valid_d & (rd_e==rs1 field | rd_e==rs2 field).
- The block does not self-stall. The top level drives stall on the fetch side and flush here.

**ID/EX update priority:** rst > flush > stall > load.
- rst: every output register to 0; register file to 0.
- flush: valid_e and all control outputs (reg_write_e … rgb_e) to 0. Data/address/PC fields are don't-care; they are loaded as normal.
- stall (no flush): all ID/EX registers hold.
- Otherwise: load the decoded values, with valid_e=valid_d. When valid_d=0, all control bits load as 0.

## Timing
- ID/EX latency: 1 cycle from instr_d/valid_d to the *_e outputs.
- hazard is same-cycle combinational, from ID/EX state plus instr_d.
- Reset value of every output: 0, including valid_e, operands and PCs.
- Reset asserted mid-stream clears everything on that edge. The first instruction presented after deassertion appears on *_e one cycle later.
- Simultaneous flush and stall: flush wins.
- A stall held N cycles keeps the *_e outputs constant for N cycles.
- rd1_e/rd2_e captured during a stall are the values held, not re-read.
- Writeback in the same cycle as a read of the same nonzero register: see Configuration.

## Configuration
- DECODE_BYPASS_EN defined: write-through bypass. A read whose address equals rd_w (≠0) while reg_write_w=1 returns result_w in the same cycle, so rd1_e/rd2_e capture the new value.
- Undefined: reads return the pre-write array contents. The new value is visible from the next cycle, and the top level must forward it.

## Test plan
- Reset then ALU reg form (tipo=00, op=10, Inm=0, rs1=3, rs2=4, rd=7), with r3=5, r4=9 → next cycle: reg_write_e=1, alu_control_e=010, rd1_e=5, rd2_e=9, rd_e=7, valid_e=1.
- Load (tipo=01, op=00) to r6, followed by an instruction reading r6 → hazard=1 during the second instruction's decode cycle; hazard=0 if the reader uses r0 or r5.
- Immediate instr_d[17:0]=18'h3FFFF with DATA_W=24 → imm_e=24'hFFFFFF; imm 18'h00010 → imm_e=24'h000010.
- stall held 3 cycles then flush=stall=1 → *_e constant for 3 cycles, then valid_e=0 and all controls 0.
- Writeback r2=0x1234 in the same cycle as decoding a read of r2 → rd1_e=0x1234 with DECODE_BYPASS_EN; old value (0) without it. A write to r0 with value 0xFF → r0 still reads 0.

Source files
------------

// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode, 2-read/1-write register file and ID/EX pipeline register.
// Optional macro DECODE_BYPASS_EN enables write-through forwarding from the writeback port.
module decode_stage_p #(
    parameter int DATA_W = 18,
    parameter int PC_W   = 9,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [32:0]       instr_d,
    input  logic              valid_d,
    input  logic [PC_W-1:0]   pc_d,
    input  logic [PC_W-1:0]   pc_plus4_d,
    input  logic              stall,
    input  logic              flush,
    input  logic              reg_write_w,
    input  logic [RA_W-1:0]   rd_w,
    input  logic [DATA_W-1:0] result_w,
    output logic              valid_e,
    output logic              reg_write_e,
    output logic              alu_src_e,
    output logic              mem_write_e,
    output logic              result_src_e,
    output logic              branch_e,
    output logic [2:0]        alu_control_e,
    output logic [1:0]        rgb_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [RA_W-1:0]   rs1_e,
    output logic [RA_W-1:0]   rs2_e,
    output logic [RA_W-1:0]   rd_e,
    output logic [PC_W-1:0]   pc_e,
    output logic [PC_W-1:0]   pc_plus4_e,
    output logic              hazard
);
    localparam int NREG = 2 ** RA_W;

    logic              inm;
    logic [1:0]        tipo;
    logic [1:0]        op;
    logic [RA_W-1:0]   rs1_f;
    logic [RA_W-1:0]   rs2_f;
    logic [RA_W-1:0]   rd_f;
    logic [DATA_W-1:0] imm_d;

    assign inm   = instr_d[32];
    assign tipo  = instr_d[31:30];
    assign op    = instr_d[29:28];
    assign rs1_f = RA_W'(instr_d[27:23]);
    assign rs2_f = RA_W'(instr_d[22:18]);
    assign rd_f  = (tipo == 2'b01) ? rs1_f : (inm ? rs2_f : RA_W'(instr_d[4:0]));
    assign imm_d = DATA_W'($signed(instr_d[17:0]));

    // Register file: entry 0 is a constant so it can never be written.
    logic [DATA_W-1:0] rf_q [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_entry
                logic [DATA_W-1:0] entry_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        entry_reg <= '0;
                    end else if (reg_write_w && rd_w == RA_W'(gi)) begin
                        entry_reg <= result_w;
                    end
                end
                assign rf_q[gi] = entry_reg;
            end
        end
    endgenerate

    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;

    always_comb begin
        rd1_d = rf_q[rs1_f];
        rd2_d = rf_q[rs2_f];
`ifdef DECODE_BYPASS_EN
        if (reg_write_w && rd_w != '0) begin
            if (rd_w == rs1_f) rd1_d = result_w;
            if (rd_w == rs2_f) rd2_d = result_w;
        end
`endif
    end

    logic       reg_write_d;
    logic       alu_src_d;
    logic       mem_write_d;
    logic       result_src_d;
    logic       branch_d;
    logic [2:0] alu_control_d;
    logic [1:0] rgb_d;

    always_comb begin
        reg_write_d   = 1'b0;
        alu_src_d     = 1'b0;
        mem_write_d   = 1'b0;
        result_src_d  = 1'b0;
        branch_d      = 1'b0;
        alu_control_d = 3'b000;
        rgb_d         = 2'b00;
        case (tipo)
            2'b00: begin
                reg_write_d   = 1'b1;
                alu_src_d     = inm;
                alu_control_d = {1'b0, op};
            end
            2'b01: begin
                if (op == 2'b00) begin
                    reg_write_d  = 1'b1;
                    alu_src_d    = 1'b1;
                    result_src_d = 1'b1;
                end else if (op == 2'b01) begin
                    mem_write_d = 1'b1;
                    alu_src_d   = 1'b1;
                end
            end
            2'b10: begin
                branch_d      = 1'b1;
                alu_control_d = 3'b001;
            end
            default: begin
                rgb_d = op;
            end
        endcase
    end

    // Control half of ID/EX: a bubble on flush, zeroed when the slot carries no instruction.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_e       <= 1'b0;
            reg_write_e   <= 1'b0;
            alu_src_e     <= 1'b0;
            mem_write_e   <= 1'b0;
            result_src_e  <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= 3'b000;
            rgb_e         <= 2'b00;
        end else if (!stall) begin
            valid_e       <= valid_d;
            reg_write_e   <= valid_d & reg_write_d;
            alu_src_e     <= valid_d & alu_src_d;
            mem_write_e   <= valid_d & mem_write_d;
            result_src_e  <= valid_d & result_src_d;
            branch_e      <= valid_d & branch_d;
            alu_control_e <= valid_d ? alu_control_d : 3'b000;
            rgb_e         <= valid_d ? rgb_d : 2'b00;
        end
    end

    // Data half of ID/EX: flush overrides stall, so the slot still loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
        end else if (flush || !stall) begin
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_e      <= imm_d;
            rs1_e      <= rs1_f;
            rs2_e      <= rs2_f;
            rd_e       <= rd_f;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
        end
    end

    assign hazard = valid_e & result_src_e & (rd_e != '0) & valid_d &
                    ((rd_e == rs1_f) | (rd_e == rs2_f));
endmodule
